// File: rtl/wddl_round_sched.sv
// Phase/round sequencer for the WDDL AES datapath: walks LOAD, then NR_ROUNDS of
// precharge/evaluate/capture, then DONE. Every output comes straight from a flop.
module wddl_round_sched #(
    parameter int NR_ROUNDS   = 10,
    parameter int PRE_CYCLES  = 1,
    parameter int EVAL_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       abort_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       load_o,
    output logic       precharge_o,
    output logic       eval_o,
    output logic       reg_en_o,
    output logic [3:0] round_o,
    output logic       final_round_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_PRE     = 3'd2,
        S_EVAL    = 3'd3,
        S_CAPTURE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [3:0] PRE_M1  = 4'(PRE_CYCLES - 1);
    localparam logic [3:0] EVAL_M1 = 4'(EVAL_CYCLES - 1);
    localparam logic [3:0] NR_R    = 4'(NR_ROUNDS);

    state_t     state_q, state_d;
    logic [3:0] phase_q, phase_d;
    logic [3:0] round_q, round_d;

    logic busy_q, busy_d;
    logic done_q, done_d;
    logic load_q, load_d;
    logic pre_q, pre_d;
    logic eval_q, eval_d;
    logic reg_en_q, reg_en_d;
    logic final_q, final_d;

    // Next-state: abort outranks every normal transition outside IDLE.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        round_d = round_q;
        if (state_q != S_IDLE && abort_i) begin
            state_d = S_IDLE;
            phase_d = 4'd0;
            round_d = 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i && !abort_i) begin
                        state_d = S_LOAD;
                    end
                end
                S_LOAD: begin
                    state_d = S_PRE;
                    phase_d = PRE_M1;
                    round_d = 4'd1;
                end
                S_PRE: begin
                    if (phase_q == 4'd0) begin
                        state_d = S_EVAL;
                        phase_d = EVAL_M1;
                    end else begin
                        phase_d = phase_q - 4'd1;
                    end
                end
                S_EVAL: begin
                    if (phase_q == 4'd0) begin
                        state_d = S_CAPTURE;
                    end else begin
                        phase_d = phase_q - 4'd1;
                    end
                end
                S_CAPTURE: begin
                    if (round_q < NR_R) begin
                        state_d = S_PRE;
                        phase_d = PRE_M1;
                        round_d = round_q + 4'd1;
                    end else begin
                        state_d = S_DONE;
                        phase_d = 4'd0;
                        round_d = 4'd0;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    phase_d = 4'd0;
                    round_d = 4'd0;
                end
            endcase
        end
    end

    // Outputs decoded from the next state so they can be registered without lag.
    always_comb begin
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
        load_d   = (state_d == S_LOAD);
        eval_d   = (state_d == S_EVAL) || (state_d == S_CAPTURE);
        pre_d    = !eval_d;
        reg_en_d = (state_d == S_CAPTURE);
        final_d  = (round_d == NR_R);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            phase_q  <= 4'd0;
            round_q  <= 4'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            load_q   <= 1'b0;
            pre_q    <= 1'b1;
            eval_q   <= 1'b0;
            reg_en_q <= 1'b0;
            final_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            round_q  <= round_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            load_q   <= load_d;
            pre_q    <= pre_d;
            eval_q   <= eval_d;
            reg_en_q <= reg_en_d;
            final_q  <= final_d;
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign load_o        = load_q;
    assign precharge_o   = pre_q;
    assign eval_o        = eval_q;
    assign reg_en_o      = reg_en_q;
    assign round_o       = round_q;
    assign final_round_o = final_q;

endmodule

// File: tb/tb_wddl_round_sched.sv
// Bench for wddl_round_sched: default instance plus a short-round instance, both
// compared every cycle against a cycle-index model of the run timeline.
module tb_wddl_round_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic s0 = 1'b0, a0 = 1'b0, s1 = 1'b0, a1 = 1'b0;

    logic bz0, dn0, ld0, pc0, ev0, re0, fn0;
    logic bz1, dn1, ld1, pc1, ev1, re1, fn1;
    logic [3:0] rn0, rn1;

    int nvec = 0;
    int nfail = 0;
    int mc0 = 0, mc1 = 0;
    int prun0 = 0, prun1 = 0;
    logic pev0 = 1'b0, pev1 = 1'b0;
    int done_c0, done_c1;

    always #5 clk = ~clk;

    wddl_round_sched dut0 (
        .clk(clk), .rst(rst), .start_i(s0), .abort_i(a0),
        .busy_o(bz0), .done_o(dn0), .load_o(ld0), .precharge_o(pc0),
        .eval_o(ev0), .reg_en_o(re0), .round_o(rn0), .final_round_o(fn0)
    );

    wddl_round_sched #(.NR_ROUNDS(1), .PRE_CYCLES(3), .EVAL_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start_i(s1), .abort_i(a1),
        .busy_o(bz1), .done_o(dn1), .load_o(ld1), .precharge_o(pc1),
        .eval_o(ev1), .reg_en_o(re1), .round_o(rn1), .final_round_o(fn1)
    );

    wire [10:0] v0 = {bz0, dn0, ld0, pc0, ev0, re0, fn0, rn0};
    wire [10:0] v1 = {bz1, dn1, ld1, pc1, ev1, re1, fn1, rn1};

    // mc = cycles since start was accepted (0 = idle, 1 = load).
    function automatic logic [10:0] exp_out(int mc, int nr, int pre, int ev);
        logic bz, dn, ld, pc, e, re, fn;
        logic [3:0] rn;
        int rl, last, off, r, p;
        bz = 0; dn = 0; ld = 0; pc = 0; e = 0; re = 0; fn = 0; rn = 4'd0;
        rl = pre + ev + 1;
        last = 2 + nr * rl;
        if (mc == 0) begin
            pc = 1;
        end else if (mc == 1) begin
            bz = 1; ld = 1; pc = 1;
        end else if (mc < last) begin
            off = mc - 2;
            r = off / rl + 1;
            p = off % rl;
            bz = 1;
            rn = 4'(r);
            fn = (r == nr);
            if (p < pre) pc = 1;
            else e = 1;
            re = (p == pre + ev);
        end else begin
            bz = 1; dn = 1; pc = 1;
        end
        return {bz, dn, ld, pc, e, re, fn, rn};
    endfunction

    function automatic int next_mc(int mc, bit s, bit a, int last);
        if (mc == 0) return (s && !a) ? 1 : 0;
        if (a) return 0;
        if (mc == last) return 0;
        return mc + 1;
    endfunction

    task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        chk("out0", v0, exp_out(mc0, 10, 1, 2));
        chk("out1", v1, exp_out(mc1, 1, 3, 1));
        chk("xor0", {10'b0, pc0 ^ ev0}, 11'd1);
        chk("xor1", {10'b0, pc1 ^ ev1}, 11'd1);
        chk("excl0", {10'b0, $onehot0({ld0, re0, dn0})}, 11'd1);
        chk("excl1", {10'b0, $onehot0({ld1, re1, dn1})}, 11'd1);
        if (ev0 && !pev0) chk("gap0", {10'b0, prun0 >= 1}, 11'd1);
        if (ev1 && !pev1) chk("gap1", {10'b0, prun1 >= 3}, 11'd1);
        prun0 = pc0 ? prun0 + 1 : 0;
        prun1 = pc1 ? prun1 + 1 : 0;
        pev0 = ev0;
        pev1 = ev1;
    endtask

    task automatic step(input bit st0, input bit ab0, input bit st1, input bit ab1);
        s0 = st0; a0 = ab0; s1 = st1; a1 = ab1;
        @(posedge clk);
        if (rst) begin
            mc0 = 0; mc1 = 0;
        end else begin
            mc0 = next_mc(mc0, st0, ab0, 42);
            mc1 = next_mc(mc1, st1, ab1, 7);
        end
        #1;
        check_all();
    endtask

    initial begin
        // reset state, then quiet idle
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
        repeat (5) step(0, 0, 0, 0);

        // nominal run on both instances, with measured done latency
        step(1, 0, 1, 0);
        done_c0 = 0; done_c1 = 0;
        for (int c = 2; c <= 46; c++) begin
            step(0, 0, 0, 0);
            if (dn0 && done_c0 == 0) done_c0 = c;
            if (dn1 && done_c1 == 0) done_c1 = c;
        end
        chk("latency0", 11'(done_c0), 11'd42);
        chk("latency1", 11'(done_c1), 11'd7);

        // abort in round 4 evaluate, then a clean rerun
        step(1, 0, 0, 0);
        repeat (14) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        chk("abort_round", {7'b0, rn0}, 11'd0);
        chk("abort_pre", {10'b0, pc0}, 11'd1);
        step(1, 0, 0, 0);
        done_c0 = 0;
        for (int c = 2; c <= 46; c++) begin
            step(0, 0, 0, 0);
            if (dn0 && done_c0 == 0) done_c0 = c;
        end
        chk("latency_rerun", 11'(done_c0), 11'd42);

        // start held high, then start together with abort while idle
        repeat (100) step(1, 0, 1, 0);
        repeat (50) step(0, 0, 0, 0);
        repeat (3) step(1, 1, 1, 1);

        // asynchronous reset mid-run, checked before any clock edge
        step(1, 0, 1, 0);
        repeat (20) step(0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        mc0 = 0; mc1 = 0;
        check_all();
        @(negedge clk);
        rst = 1'b0;
        repeat (5) step(0, 0, 0, 0);

        // random start/abort traffic
        repeat (400) step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/wddl_round_sched.md
# wddl_round_sched

Sequencing controller for the WDDL AES round datapath built from the dual-rail standard-cell gates. Alternates the datapath between precharge and evaluate phases, steps the round counter, and strobes the state/key registers once per round. Sits between the host-side start/done handshake and the round-logic enables. All outputs are glitch-free registered levels, as WDDL requires.

## Interface

- NR_ROUNDS, 10: number of AES rounds; legal range 1..15.
- PRE_CYCLES, 1: clock cycles per precharge phase; legal range 1..15.
- EVAL_CYCLES, 2: clock cycles per evaluate phase; legal range 1..15.

- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  request one encryption; sampled only in IDLE.
- abort_i  in  1  synchronous abort of a running encryption.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse when the result is valid in the state register.
- load_o  out  1  loads plaintext and key into the state and key registers.
- precharge_o  out  1  forces both rails of all datapath inputs to 0.
- eval_o  out  1  releases the datapath to evaluate.
- reg_en_o  out  1  captures the round result into the state register and advances the key schedule.
- round_o  out  4  current round number: 0 in IDLE/LOAD/DONE, 1..NR_ROUNDS otherwise.
- final_round_o  out  1  high while round_o == NR_ROUNDS; the datapath bypasses MixColumns.

## Operation

- States: IDLE, LOAD, PRE, EVAL, CAPTURE, DONE. State, phase counter (4 b) and round counter (4 b) are registered. Every output is a registered decode: no combinational path from inputs to outputs.
- IDLE: precharge_o=1. start_i=1 and abort_i=0 -> LOAD.
- LOAD, 1 cycle: load_o=1, precharge_o=1 -> PRE, round=1.
- PRE, PRE_CYCLES cycles: precharge_o=1 -> EVAL.
- EVAL, EVAL_CYCLES cycles: eval_o=1 -> CAPTURE.
- CAPTURE, 1 cycle: reg_en_o=1, eval_o=1, so the evaluated values stay stable while they are captured.
  - If round < NR_ROUNDS: round+1 -> PRE.
  - Otherwise -> DONE.
- DONE, 1 cycle: done_o=1, precharge_o=1, round_o=0 -> IDLE.
- Invariants:
  - precharge_o and eval_o are never both 1, and at least one of them is always 1.
  - Every pair of evaluate phases is separated by at least PRE_CYCLES of precharge.
  - load_o, reg_en_o and done_o are mutually exclusive.
- abort_i=1 in any non-IDLE state -> IDLE on the next edge: no done_o, counters cleared, precharge_o=1 in the following cycle. abort_i has priority over start_i and over all normal transitions.
- start_i is ignored while busy_o=1; it is not queued.
- start_i held high through DONE: IDLE is entered for at least one cycle, then a new run starts.

## Timing

- Reset (asynchronous assert, synchronous release):
  - state IDLE, counters 0.
  - precharge_o=1.
  - busy_o, done_o, load_o, eval_o, reg_en_o, final_round_o = 0; round_o=0.
- Reset asserted mid-run: outputs take their reset values immediately and no done_o is produced.
- start_i sampled high at edge 0 while IDLE:
  - LOAD occupies cycle 1.
  - Round r occupies cycles 2+(r-1)·R through 1+r·R, where R = PRE_CYCLES+EVAL_CYCLES+1.
  - done_o is high in cycle 2+NR_ROUNDS·R. Defaults: R=4, so done_o is in cycle 42.
- busy_o rises in cycle 1 and falls after the DONE cycle. The earliest following start is sampled at the first IDLE edge, so back-to-back runs have 1 idle cycle between them.
- Phase counter counts down from the phase length minus 1 and transitions at 0. With PRE_CYCLES=1 or EVAL_CYCLES=1 the phase lasts exactly one cycle.

## Test plan

- Reset and idle: assert rst mid-cycle with no clock edge -> outputs reach reset values immediately; precharge_o=1, round_o=0. Release and hold for 5 cycles -> nothing changes.
- Nominal run with defaults: start pulse at edge 0 ->
  - load_o in cycle 1.
  - precharge_o/eval_o/eval_o/reg_en_o pattern repeats 10 times.
  - round_o steps 1..10; final_round_o is high only in cycles 38–41.
  - done_o is a single pulse in cycle 42; busy_o is low in cycle 43.
- Parameter sweep: NR_ROUNDS=1, PRE_CYCLES=3, EVAL_CYCLES=1 -> done_o in cycle 2+5=7; phase lengths are exact.
- Abort mid-evaluate: abort_i in round 4 EVAL -> IDLE next cycle, precharge_o=1, round_o=0, no done_o. A new start then completes normally with 42-cycle latency.
- Start collisions:
  - start_i held high continuously -> runs separated by exactly 1 IDLE cycle.
  - start_i and abort_i high together in IDLE -> stays in IDLE.
- Invariant checker over all runs:
  - precharge_o XOR eval_o is always 1.
  - load_o, reg_en_o and done_o are never high together.
  - No eval_o rise occurs without at least PRE_CYCLES of precharge_o before it.
